range_bin_classifier: RTL and testbench
=======================================

Name: range_bin_classifier

Overview:
- Classifies each unsigned input word into one of 2^LOG_BINS bins against a programmable, ascending threshold table.
- Uses a single shared less-than comparator, sequenced by an FSM that performs a binary search with one comparison per probe.
- Sits between a valid/ready producer and consumer. A separate config port loads the table.

Parameters:
- WIDTH, 16, data and threshold width in bits
- LOG_BINS, 3, log2 of bin count; table holds 2^LOG_BINS-1 thresholds at addresses 1..2^LOG_BINS-1

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  threshold write strobe
- cfg_addr  in  LOG_BINS  threshold index (1..2^LOG_BINS-1)
- cfg_data  in  WIDTH  threshold value
- cfg_err  out  1  one-cycle pulse: rejected write
- in_valid  in  1  input word offered
- in_ready  out  1  block can accept
- in_dat  in  WIDTH  input word, unsigned
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_bin  out  LOG_BINS  bin index = count of thresholds <= word (sorted table)
- out_dat  out  WIDTH  the classified word, echoed
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; out_valid=0, out_bin=0, out_dat=0, cfg_err=0, busy=0, in_ready=1.
  - All thresholds set to all-ones.
- States:
  - IDLE: in_ready=1. On in_valid, latch dat_r=in_dat, idx=0, bit=LOG_BINS-1, then go to PROBE.
  - PROBE: probe=idx|(1<<bit). Register lt_r = (dat_r < T[probe]), unsigned, full WIDTH. Go to DECIDE.
  - DECIDE: if !lt_r, set idx|=1<<bit. If bit==0 go to DONE; else bit-=1 and go to PROBE.
  - DONE: out_valid=1, out_bin=idx, out_dat=dat_r. On out_ready, go to IDLE.
- Exactly one comparator evaluation per PROBE cycle; no other compare paths.
- Latency: with the accept edge at cycle 0, out_valid rises at cycle 2*LOG_BINS+1 (cycle 7 at the default).
- Throughput: one word per 2*LOG_BINS+2 cycles minimum. No overlap; in_ready=0 outside IDLE.
- Output hold: out_valid, out_bin and out_dat stay stable while out_ready=0. out_valid drops the cycle after the handshake.
- Config writes:
  - Accepted only in IDLE with cfg_addr!=0; T[cfg_addr] updates at that edge.
  - cfg_we outside IDLE, or with cfg_addr==0, is ignored; cfg_err pulses high the next cycle.
- Simultaneous cfg_we and in_valid in IDLE: both take effect. The search sees the new threshold, since the first probe reads the table one cycle later.
- Unsorted table: out_bin is whatever the binary-search algorithm above yields. No error flag.
- Equal to threshold: dat == T[k] counts T[k] as <= dat, so the word lands in the upper bin.
- Reset mid-search or in DONE: the pending result is discarded with no output pulse, and the table returns to all-ones.

Test Plan:
Setup for tests 1–3: WIDTH=16, LOG_BINS=3, T[1..7]=10,20,30,40,50,60,70.
1. in_dat=35 accepted at cycle 0 -> out_valid first high at cycle 7, out_bin=3, out_dat=35, busy=1 during cycles 1–7.
2. in_dat = 9, 10, 69, 70, 0xFFFF back-to-back, out_ready=1 -> out_bin = 0, 1, 6, 7, 7; each accept is 8 cycles after the previous one.
3. out_ready=0 for 5 cycles after out_valid -> out_valid, out_bin and out_dat held constant; in_ready=0; a second in_valid is not accepted until the cycle after the handshake.
4. Config rejects:
   - cfg_we (addr=3, data=5) during PROBE of in_dat=35 -> cfg_err pulse one cycle, T[3] stays 30, out_bin=3.
   - cfg_we with addr=0 in IDLE -> cfg_err pulse, no table change.
5. Simultaneous write and accept in IDLE: cfg_we (addr=4, data=36) together with in_dat=37 -> out_bin=4.
6. rst_n low during DECIDE -> immediately out_valid=0, busy=0, in_ready=1; no spurious result after release. Then in_dat=0x1234 -> out_bin=0, and in_dat=0xFFFF -> out_bin=7 (all-ones table).

Source files
------------

// File: rtl/range_bin_classifier.sv
// Classifies unsigned words into 2**LOG_BINS bins against a programmable threshold
// table, using one shared less-than comparator driven by a binary-search FSM.
module range_bin_classifier #(
   parameter int WIDTH    = 16,
   parameter int LOG_BINS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [LOG_BINS-1:0] cfg_addr,
   input  logic [WIDTH-1:0]    cfg_data,
   output logic                cfg_err,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_dat,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LOG_BINS-1:0] out_bin,
   output logic [WIDTH-1:0]    out_dat,
   output logic                busy
);
   localparam int NUM_THR = (1 << LOG_BINS) - 1;
   localparam logic [LOG_BINS-1:0] TOP_BIT = LOG_BINS'(1) << (LOG_BINS - 1);

   // Handshakes: a word transfers on a rising edge with in_valid && in_ready, a
   // result with out_valid && out_ready; out_valid and its data hold until then.

   typedef enum logic [1:0] {IDLE, PROBE, DECIDE, DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0]    thr [1:NUM_THR];
   logic [WIDTH-1:0]    dat_r;
   logic [LOG_BINS-1:0] idx_r;
   logic [LOG_BINS-1:0] mask_r;
   logic [LOG_BINS-1:0] probe;
   logic                lt_r;

   // mask_r is the one-hot form of the search bit; probe is the address tested.
   assign probe = idx_r | mask_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = PROBE;
         PROBE:   state_nx = DECIDE;
         DECIDE:  state_nx = mask_r[0] ? DONE : PROBE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      out_bin   = '0;
      out_dat   = '0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         DONE: begin
            out_valid = 1'b1;
            out_bin   = idx_r;
            out_dat   = dat_r;
         end
         default: ;
      endcase
   end

   // The only comparator: evaluated once per PROBE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dat_r  <= '0;
         idx_r  <= '0;
         mask_r <= '0;
         lt_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               dat_r  <= in_dat;
               idx_r  <= '0;
               mask_r <= TOP_BIT;
            end
            PROBE:  lt_r <= dat_r < thr[probe];
            DECIDE: begin
               if (!lt_r) idx_r <= probe;
               mask_r <= mask_r >> 1;
            end
            default: ;
         endcase
      end
   end

   // Table writes land at the accept edge too, so a simultaneous search sees them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= NUM_THR; k++) thr[k] <= '1;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         if (cfg_we) begin
            if (state == IDLE && cfg_addr != '0) thr[cfg_addr] <= cfg_data;
            else                                 cfg_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_range_bin_classifier.sv
// Bench for range_bin_classifier: a counting reference model plus a per-cycle
// compare process, and directed scenarios with hand-computed results.
module tb_range_bin_classifier;
   localparam int W  = 16;
   localparam int LB = 3;
   localparam int NT = (1 << LB) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [LB-1:0] cfg_addr = '0;
   logic [W-1:0]  cfg_data = '0;
   logic          cfg_err;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_dat = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [LB-1:0] out_bin;
   logic [W-1:0]  out_dat;
   logic          busy;

   range_bin_classifier #(.WIDTH(W), .LOG_BINS(LB)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_dat(in_dat),
      .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_dat(out_dat),
      .busy(busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0]    m_thr [1:NT];
   logic            m_busy = 1'b0;
   int              m_cnt = 0;
   logic            m_err = 1'b0;
   logic [W+LB-1:0] exp_q[$];

   // Bin of a word against a sorted table: how many thresholds are <= it.
   function automatic logic [LB-1:0] ref_bin(input logic [W-1:0] w);
      int n = 0;
      for (int k = 1; k <= NT; k++) if (m_thr[k] <= w) n++;
      return LB'(n);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= NT; k++) m_thr[k] = '1;
         m_busy = 1'b0;
         m_cnt  = 0;
         m_err  = 1'b0;
         exp_q.delete();
      end else begin
         m_err = 1'b0;
         if (m_busy) begin
            if (cfg_we) m_err = 1'b1;
            if (m_cnt == 2 * LB) begin
               if (out_ready) begin
                  m_busy = 1'b0;
                  void'(exp_q.pop_front());
               end
            end else m_cnt++;
         end else begin
            if (cfg_we) begin
               if (cfg_addr == '0) m_err = 1'b1;
               else                m_thr[cfg_addr] = cfg_data;
            end
            if (in_valid) begin
               m_busy = 1'b1;
               m_cnt  = 0;
               exp_q.push_back({in_dat, ref_bin(in_dat)});
            end
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic            exp_ov;
      logic [W+LB-1:0] head;
      exp_ov = m_busy && (m_cnt == 2 * LB);
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      if (exp_ov) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL exp_q: result expected but queue empty (t=%0t)", $time);
         end else begin
            head = exp_q[0];
            chk("out_bin", 32'(out_bin), 32'(head[LB-1:0]));
            chk("out_dat", 32'(out_dat), 32'(head[W+LB-1:LB]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cfg_write(input logic [LB-1:0] a, input logic [W-1:0] d);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Called at a negedge. Offers one word, checks latency and result, holds
   // out_ready low for `hold` cycles (optionally offering `nxt` meanwhile).
   task automatic send(input logic [W-1:0] word, input logic [LB-1:0] exp_bin,
                       input int hold, input bit early, input logic [W-1:0] nxt,
                       output int acc_edge, output int hs_edge);
      int guard;
      int lat;
      in_valid = 1'b1;
      in_dat   = word;
      guard    = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: word %0h not accepted", word);
      end
      @(negedge clk);
      acc_edge  = edge_n;
      in_valid  = 1'b0;
      out_ready = (hold == 0);
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(7));
      chk("lit_bin", 32'(out_bin), 32'(exp_bin));
      chk("lit_dat", 32'(out_dat), 32'(word));
      for (int h = 0; h < hold; h++) begin
         if (early) begin
            in_valid = 1'b1;
            in_dat   = nxt;
         end
         chk("hold_valid", 32'(out_valid), 32'(1));
         chk("hold_bin", 32'(out_bin), 32'(exp_bin));
         chk("hold_dat", 32'(out_dat), 32'(word));
         chk("hold_in_ready", 32'(in_ready), 32'(0));
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      hs_edge = edge_n;
   endtask

   task automatic wait_out(input string name);
      int guard = 0;
      while (!out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: out_valid never rose", name);
      end
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int a0, a1, h0, h1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_cfg_err", 32'(cfg_err), 32'(0));
      chk("rst_out_bin", 32'(out_bin), 32'(0));
      chk("rst_out_dat", 32'(out_dat), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= NT; k++) cfg_write(LB'(k), W'(10 * k));

      // single word, then back-to-back with fixed spacing
      send(16'd35, 3'd3, 0, 1'b0, '0, a0, h0);
      send(16'd9, 3'd0, 0, 1'b0, '0, a0, h0);
      send(16'd10, 3'd1, 0, 1'b0, '0, a1, h1);
      chk("spacing_1", 32'(a1 - a0), 32'(8));
      send(16'd69, 3'd6, 0, 1'b0, '0, a0, h0);
      chk("spacing_2", 32'(a0 - a1), 32'(8));
      send(16'd70, 3'd7, 0, 1'b0, '0, a1, h1);
      send(16'hFFFF, 3'd7, 0, 1'b0, '0, a0, h0);
      chk("spacing_3", 32'(a0 - a1), 32'(8));

      // back-pressure with a competing word offered during the hold
      send(16'd55, 3'd5, 5, 1'b1, 16'd20, a0, h0);
      send(16'd20, 3'd2, 0, 1'b0, '0, a1, h1);
      chk("accept_after_hs", 32'(a1), 32'(h0 + 1));

      // rejected write during a search
      in_valid = 1'b1;
      in_dat   = 16'd35;
      @(negedge clk);
      in_valid = 1'b0;
      cfg_write(3'd3, 16'd5);
      chk("busy_write_err", 32'(cfg_err), 32'(1));
      @(negedge clk);
      chk("err_one_cycle", 32'(cfg_err), 32'(0));
      wait_out("busy_write");
      chk("busy_write_bin", 32'(out_bin), 32'(3));
      @(negedge clk);
      // rejected write to address 0
      cfg_write(3'd0, 16'd0);
      chk("addr0_err", 32'(cfg_err), 32'(1));
      @(negedge clk);
      send(16'd25, 3'd2, 0, 1'b0, '0, a0, h0);

      // simultaneous write and accept
      cfg_we   = 1'b1;
      cfg_addr = 3'd4;
      cfg_data = 16'd36;
      in_valid = 1'b1;
      in_dat   = 16'd37;
      @(negedge clk);
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      chk("simul_no_err", 32'(cfg_err), 32'(0));
      wait_out("simul");
      chk("simul_bin", 32'(out_bin), 32'(4));
      @(negedge clk);

      // reset in the middle of a search
      in_valid = 1'b1;
      in_dat   = 16'd45;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_in_ready", 32'(in_ready), 32'(1));
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      send(16'h1234, 3'd0, 0, 1'b0, '0, a0, h0);
      send(16'hFFFF, 3'd7, 0, 1'b0, '0, a0, h0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
